// File: rtl/ofdm_cp_serializer.sv
// rtl/ofdm_cp_serializer.sv - captures a parallel I/Q OFDM symbol and streams it
// out serially with a cyclic prefix prepended, valid/ready on both sides.
module ofdm_cp_serializer #(
   parameter int N_SAMP = 8,
   parameter int SAMP_W = 16,
   parameter int CP_LEN = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_SAMP*SAMP_W-1:0] in_phase,
   input  logic [N_SAMP*SAMP_W-1:0] in_quad,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SAMP_W-1:0]        out_i,
   output logic [SAMP_W-1:0]        out_q,
   output logic                     out_sop,
   output logic                     out_eop,
   output logic [15:0]              sym_cnt
);

   localparam int IDX_W = (N_SAMP > 1) ? $clog2(N_SAMP) : 1;
   localparam logic [IDX_W-1:0] LAST_D = IDX_W'(N_SAMP - 1);
   localparam logic [IDX_W-1:0] LAST_C = IDX_W'((CP_LEN > 0) ? CP_LEN - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_CP, S_DATA} state_t;

   // With no prefix configured a fresh symbol starts directly in DATA.
   localparam state_t FIRST = (CP_LEN == 0) ? S_DATA : S_CP;

   state_t                   state, state_nxt;
   logic [IDX_W-1:0]         idx, idx_nxt;
   logic [N_SAMP*SAMP_W-1:0] hold_i, hold_q;
   logic                     last_d, accept;
   int                       samp_k;
   logic [SAMP_W-1:0]        sel_i, sel_q;

   always_comb begin
      last_d    = (state == S_DATA) && (idx == LAST_D);
      in_ready  = (state == S_IDLE) || (last_d && out_ready);
      accept    = in_valid && in_ready;
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = FIRST;
               idx_nxt   = '0;
            end
         end
         S_CP: begin
            if (out_ready) begin
               if (idx == LAST_C) begin
                  state_nxt = S_DATA;
                  idx_nxt   = '0;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         S_DATA: begin
            if (out_ready) begin
               if (idx == LAST_D) begin
                  state_nxt = accept ? FIRST : S_IDLE;
                  idx_nxt   = '0;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   // Prefix beats replay the tail samples N_SAMP-CP_LEN .. N_SAMP-1.
   always_comb begin
      samp_k = (state == S_CP) ? (N_SAMP - CP_LEN + int'(idx)) : int'(idx);
      sel_i  = '0;
      sel_q  = '0;
      for (int j = 0; j < N_SAMP; j++) begin
         if (j == samp_k) begin
            sel_i = hold_i[SAMP_W*(N_SAMP-j)-1 -: SAMP_W];
            sel_q = hold_q[SAMP_W*(N_SAMP-j)-1 -: SAMP_W];
         end
      end
      out_valid = (state != S_IDLE);
      out_i     = out_valid ? sel_i : '0;
      out_q     = out_valid ? sel_q : '0;
      out_sop   = (state == FIRST) && (idx == '0);
      out_eop   = last_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         idx     <= '0;
         hold_i  <= '0;
         hold_q  <= '0;
         sym_cnt <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (accept) begin
            hold_i <= in_phase;
            hold_q <= in_quad;
         end
         if (last_d && out_ready)
            sym_cnt <= sym_cnt + 16'd1;
      end
   end

endmodule
